// File: rtl/join_pkg.sv
// Shared types and constants for the hash-join datapath (feeder, partitioner, hash table).
// Pure declarations; no logic.
package join_pkg;

    localparam int KEY_W   = 32;
    localparam int TUPLE_W = 64;
    localparam int HASH_W  = 32;

    localparam int unsigned       DEFAULT_ROW_BITS  = 3;
    localparam logic [HASH_W-1:0] DEFAULT_HASH_MULT = 32'h9E3779B1;

    typedef enum logic [2:0] {
        IDLE,
        BUILD,
        BUILD_FLUSH,
        PROBE,
        PROBE_FLUSH,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/mult_hash.sv
// Multiplicative key hash: top ROW_BITS of (key*HASH_MULT mod 2^32), zero-extended.
// Purely combinational, no backpressure.
module mult_hash
    import join_pkg::*;
#(
    parameter int unsigned       ROW_BITS  = DEFAULT_ROW_BITS,
    parameter logic [HASH_W-1:0] HASH_MULT = DEFAULT_HASH_MULT
) (
    input  logic [KEY_W-1:0]  key,
    output logic [HASH_W-1:0] hash
);

    logic [HASH_W-1:0] product;

    always_comb begin
        product = key * HASH_MULT;
        hash    = product >> (HASH_W - ROW_BITS);
    end

endmodule

// File: rtl/join_tuple_feeder.sv
// Sequences a join job (build, drain, probe, done), hashing each tuple into a 1-entry output register.
// Latency 1; s_ready drops when the active port's register is full and not being drained.
module join_tuple_feeder
    import join_pkg::*;
#(
    parameter int unsigned       ROW_BITS  = DEFAULT_ROW_BITS,
    parameter logic [HASH_W-1:0] HASH_MULT = DEFAULT_HASH_MULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [TUPLE_W-1:0] s_tuple,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [TUPLE_W-1:0] tuple_build,
    output logic [HASH_W-1:0]  hash_build,
    output logic               input_valid_build,
    input  logic               build_ready,
    output logic [TUPLE_W-1:0] tuple_probe,
    output logic [HASH_W-1:0]  hash_probe,
    output logic               input_valid_probe,
    input  logic               probe_ready,
    output logic               start_probing,
    output logic [31:0]        build_count,
    output logic [31:0]        probe_count,
    output logic               done
);

    feeder_state_t     state;
    logic [HASH_W-1:0] s_hash;
    logic              build_side;
    logic              out_vld;
    logic              out_rdy;
    logic              accept;
    logic              build_xfer;
    logic              probe_xfer;

    mult_hash #(
        .ROW_BITS  (ROW_BITS),
        .HASH_MULT (HASH_MULT)
    ) u_hash (
        .key  (s_tuple[KEY_W-1:0]),
        .hash (s_hash)
    );

    always_comb begin
        build_side = (state == BUILD) || (state == BUILD_FLUSH);
        out_vld    = build_side ? input_valid_build : input_valid_probe;
        out_rdy    = build_side ? build_ready : probe_ready;
        s_ready    = ((state == BUILD) || (state == PROBE)) && (!out_vld || out_rdy);
        accept     = s_valid && s_ready;
        build_xfer = input_valid_build && build_ready;
        probe_xfer = input_valid_probe && probe_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            tuple_build       <= '0;
            hash_build        <= '0;
            input_valid_build <= 1'b0;
            tuple_probe       <= '0;
            hash_probe        <= '0;
            input_valid_probe <= 1'b0;
            start_probing     <= 1'b0;
            build_count       <= '0;
            probe_count       <= '0;
            done              <= 1'b0;
        end else begin
            if (build_xfer) begin
                build_count <= build_count + 32'd1;
            end
            if (probe_xfer) begin
                probe_count <= probe_count + 32'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= BUILD;
                        build_count   <= '0;
                        probe_count   <= '0;
                        start_probing <= 1'b0;
                    end
                end

                BUILD: begin
                    // Accept while draining keeps the register full at one tuple per cycle.
                    if (accept) begin
                        tuple_build       <= s_tuple;
                        hash_build        <= s_hash;
                        input_valid_build <= 1'b1;
                        if (s_last) begin
                            state <= BUILD_FLUSH;
                        end
                    end else if (build_xfer) begin
                        input_valid_build <= 1'b0;
                    end
                end

                BUILD_FLUSH: begin
                    // An empty register means the final transfer was on an earlier cycle, so
                    // build_ready seen now is the table reporting its last write complete.
                    if (build_xfer) begin
                        input_valid_build <= 1'b0;
                    end else if (!input_valid_build && build_ready) begin
                        state         <= PROBE;
                        start_probing <= 1'b1;
                        tuple_build   <= '0;
                        hash_build    <= '0;
                    end
                end

                PROBE: begin
                    if (accept) begin
                        tuple_probe       <= s_tuple;
                        hash_probe        <= s_hash;
                        input_valid_probe <= 1'b1;
                        if (s_last) begin
                            state <= PROBE_FLUSH;
                        end
                    end else if (probe_xfer) begin
                        input_valid_probe <= 1'b0;
                    end
                end

                PROBE_FLUSH: begin
                    if (probe_xfer) begin
                        input_valid_probe <= 1'b0;
                    end else if (!input_valid_probe) begin
                        state       <= DONE;
                        done        <= 1'b1;
                        tuple_probe <= '0;
                        hash_probe  <= '0;
                    end
                end

                DONE: begin
                    if (start) begin
                        state         <= IDLE;
                        done          <= 1'b0;
                        start_probing <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
